// File: rtl/solar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// solar_pkg : shared FSM state type, default sizes and channel names
// Rev 1.0
// ---------------------------------------------------------------------------
package solar_pkg;

  localparam int SOLAR_NUM_CH     = 4;
  localparam int SOLAR_DATA_W     = 12;
  localparam int SOLAR_SETTLE_CYC = 8;

  localparam int CH_VPANEL = 0;
  localparam int CH_IPANEL = 1;
  localparam int CH_TEMP   = 2;
  localparam int CH_IRR    = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_SETTLE    = 3'd2,
    S_CONVERT   = 3'd3,
    S_STORE     = 3'd4,
    S_NEXT      = 3'd5
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/solar_adc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// solar_adc_if : channel select and req/ack conversion handshake to the ADC
// Rev 1.0
// ---------------------------------------------------------------------------
interface solar_adc_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  logic [CH_W-1:0]   adc_ch_o;
  logic              adc_req_o;
  logic              adc_ack_i;
  logic [DATA_W-1:0] adc_data_i;

  modport master (output adc_ch_o, adc_req_o, input adc_ack_i, adc_data_i);
  modport slave  (input adc_ch_o, adc_req_o, output adc_ack_i, adc_data_i);
endinterface
`default_nettype wire

// File: rtl/solar_period_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// solar_period_timer : reloadable down-counter producing the sweep tick
// Rev 1.0
// ---------------------------------------------------------------------------
module solar_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt;

  // A zero count ticks in the same cycle, so period 0 ticks every cycle.
  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period;
    end else if (run) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/solar_adc_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// solar_adc_scheduler : periodic sweep of masked sense channels through the
// shared ADC. Macro SOLAR_ADC_TIMEOUT_EN adds an ack timeout.   Rev 1.0
// ---------------------------------------------------------------------------
module solar_adc_scheduler
  import solar_pkg::*;
#(
  parameter int  NUM_CH      = SOLAR_NUM_CH,
  parameter int  DATA_W      = SOLAR_DATA_W,
  parameter int  SETTLE_CYC  = SOLAR_SETTLE_CYC,
  parameter int  PERIOD_W    = 16,
  parameter int  TIMEOUT_CYC = 255,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  input  logic                clr_i,
  solar_adc_if.master         adc,
  output logic                sample_valid_o,
  output logic [CH_W-1:0]     sample_ch_o,
  output logic [DATA_W-1:0]   sample_data_o,
  input  logic [CH_W-1:0]     rd_ch_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                sweep_done_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                timeout_err_o
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  sched_state_t      state, state_n;
  logic              tick, timer_load, timer_run;
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   cur_ch, next_ch;
  logic              found;
  logic [SET_W-1:0]  settle_cnt;
  logic              settle_last;
  logic              req;
  logic              to_last;
  logic [DATA_W-1:0] data_lat;
  logic [DATA_W-1:0] results [NUM_CH];
  logic              sweep_start, sel, conv_start, capture, store, done, to_abort;

  assign timer_load = (state == S_IDLE) && enable_i;
  assign timer_run  = (state != S_IDLE);

  solar_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .load   (timer_load),
    .run    (timer_run),
    .period (period_i),
    .tick   (tick)
  );

  // Lowest still-pending channel of the latched sweep mask.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

  assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));

`ifdef SOLAR_ADC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_last = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)               to_cnt <= '0;
    else if (conv_start)         to_cnt <= '0;
    else if (state == S_CONVERT) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)     timeout_err_o <= 1'b0;
    else if (to_abort) timeout_err_o <= 1'b1;
    else if (clr_i)    timeout_err_o <= 1'b0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign to_last        = 1'b0;
  assign timeout_err_o  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n     = state;
    sweep_start = 1'b0;
    sel         = 1'b0;
    conv_start  = 1'b0;
    capture     = 1'b0;
    store       = 1'b0;
    done        = 1'b0;
    to_abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable_i) state_n = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!enable_i) begin
          state_n = S_IDLE;
        end else if (tick) begin
          sweep_start = 1'b1;
          state_n     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!enable_i) begin
          state_n = S_IDLE;
        end else if (found) begin
          sel     = 1'b1;
          state_n = S_SETTLE;
        end else begin
          done    = 1'b1;
          state_n = S_WAIT_TICK;
        end
      end
      S_SETTLE: begin
        if (!enable_i) begin
          state_n = S_IDLE;
        end else if (settle_last) begin
          conv_start = 1'b1;
          state_n    = S_CONVERT;
        end
      end
      // A started handshake is always allowed to finish, even when disabled.
      S_CONVERT: begin
        if (adc.adc_ack_i) begin
          capture = 1'b1;
          state_n = S_STORE;
        end else if (to_last) begin
          to_abort = 1'b1;
          state_n  = enable_i ? S_NEXT : S_IDLE;
        end
      end
      S_STORE: begin
        store   = 1'b1;
        state_n = enable_i ? S_NEXT : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pending        <= '0;
      cur_ch         <= '0;
      settle_cnt     <= '0;
      req            <= 1'b0;
      data_lat       <= '0;
      sample_valid_o <= 1'b0;
      sample_ch_o    <= '0;
      sample_data_o  <= '0;
      sweep_done_o   <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      sample_valid_o <= store;
      sweep_done_o   <= done;

      if (sweep_start) begin
        pending <= ch_mask_i;
      end else if (sel) begin
        pending <= pending & ~(NUM_CH'(1) << next_ch);
      end

      if (sel) begin
        cur_ch     <= next_ch;
        settle_cnt <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      if (conv_start)              req <= 1'b1;
      else if (capture || to_abort) req <= 1'b0;

      if (capture) data_lat <= adc.adc_data_i;

      if (store) begin
        sample_ch_o   <= cur_ch;
        sample_data_o <= data_lat;
      end

      if (sweep_start)                      busy_o <= 1'b1;
      else if (done || state_n == S_IDLE)   busy_o <= 1'b0;

      if (tick && busy_o) overrun_o <= 1'b1;
      else if (clr_i)     overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) results[i] <= '0;
    end else if (store) begin
      results[cur_ch] <= data_lat;
    end
  end

  assign rd_data_o      = results[rd_ch_i];
  assign adc.adc_ch_o   = cur_ch;
  assign adc.adc_req_o  = req;
endmodule
`default_nettype wire

// File: tb/tb_solar_adc_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_solar_adc_scheduler : directed stimulus, queued expected events, monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_solar_adc_scheduler;
  import solar_pkg::*;

  localparam int CH_W   = 2;
  localparam int DATA_W = 12;

  logic        clk = 1'b0;
  logic        rst_n, enable, clr;
  logic [15:0] period;
  logic [3:0]  mask;
  logic [1:0]  rd_ch;
  logic        sample_valid, sweep_done, busy, overrun, timeout_err;
  logic [1:0]  sample_ch;
  logic [11:0] sample_data, rd_data;

  always #5 clk = ~clk;

  solar_adc_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  solar_adc_scheduler #(
    .NUM_CH(4), .DATA_W(DATA_W), .SETTLE_CYC(8), .PERIOD_W(16), .TIMEOUT_CYC(255)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(enable), .period_i(period),
    .ch_mask_i(mask), .clr_i(clr), .adc(bus),
    .sample_valid_o(sample_valid), .sample_ch_o(sample_ch), .sample_data_o(sample_data),
    .rd_ch_i(rd_ch), .rd_data_o(rd_data), .sweep_done_o(sweep_done),
    .busy_o(busy), .overrun_o(overrun), .timeout_err_o(timeout_err)
  );

  typedef struct packed {
    logic        done;
    logic [1:0]  ch;
    logic [11:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   t_samp[$];
  int   t_done[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ack_delay = 3;
  int   age = 0;
  int   ch1_req_cyc = 0;
  logic req_seen = 1'b0;
  logic hold_en = 1'b0;
  logic [1:0]  hold_ch = 2'd0;
  logic [11:0] data_base = 12'h100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_s(input logic [1:0] ch);
    ev_t e;
    e.done = 1'b0; e.ch = ch; e.data = data_base + 12'(ch);
    exp_q.push_back(e);
  endtask

  task automatic push_d();
    ev_t e;
    e.done = 1'b1; e.ch = 2'd0; e.data = 12'd0;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic is_done);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got ch=%0d data=0x%0h, required no event",
               is_done ? "done" : "sample", sample_ch, sample_data);
    end else begin
      e = exp_q.pop_front();
      if (e.done != is_done || (!is_done && (e.ch != sample_ch || e.data != sample_data))) begin
        n_fail++;
        $display("FAIL sb_event: got done=%0d ch=%0d data=0x%0h, required done=%0d ch=%0d data=0x%0h",
                 is_done, sample_ch, sample_data, e.done, e.ch, e.data);
      end
    end
  endtask

  // ADC model: ack ack_delay cycles after req rises, data = base + channel.
  initial begin
    bus.adc_ack_i  = 1'b0;
    bus.adc_data_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.adc_ack_i = 1'b0;
      if (bus.adc_req_o && !(hold_en && bus.adc_ch_o == hold_ch)) begin
        if (age == ack_delay) begin
          bus.adc_ack_i  = 1'b1;
          bus.adc_data_i = data_base + 12'(bus.adc_ch_o);
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: compares every presented sample / done pulse against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.adc_req_o) req_seen = 1'b1;
      if (bus.adc_req_o && bus.adc_ch_o == 2'(CH_IPANEL)) ch1_req_cyc++;
      if (sample_valid) begin
        t_samp.push_back(cyc);
        check_ev(1'b0);
      end
      if (sweep_done) begin
        t_done.push_back(cyc);
        check_ev(1'b1);
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return sweep_done;
      1:       return sample_valid;
      2:       return bus.adc_req_o;
      3:       return busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sig(w)) break;
    end
    if (k == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles, required event", name, budget);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; period = 16'd20; mask = 4'hF; rd_ch = 2'd0;
    idle_cycles(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(bus.adc_req_o), 0);
    chk("rst_flags", 32'({sample_valid, sweep_done, overrun, timeout_err}), 0);
    chk("rst_rd", 32'(rd_data), 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Full sweep, ack 3 cycles after req.
    t_samp.delete(); t_done.delete();
    data_base = 12'h100; ack_delay = 3; mask = 4'b1111; period = 16'd20;
    push_s(2'(CH_VPANEL)); push_s(2'(CH_IPANEL)); push_s(2'(CH_TEMP)); push_s(2'(CH_IRR)); push_d();
    enable = 1'b1;
    wait_for(0, 400, "t1_done");
    enable = 1'b0;
    idle_cycles(3);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);
    chk("t1_sample_gap01", 32'(t_samp[1] - t_samp[0]), 14);
    chk("t1_sample_gap23", 32'(t_samp[3] - t_samp[2]), 14);
    chk("t1_done_after_last", 32'(t_done[0] - t_samp[3]), 1);
    chk("t1_overrun", 32'(overrun), 1);
    rd_ch = 2'(CH_TEMP); #1;
    chk("t1_rd_temp", 32'(rd_data), 32'h102);
    rd_ch = 2'(CH_VPANEL); #1;
    chk("t1_rd_vpanel", 32'(rd_data), 32'h100);

    // Sparse mask; mid-sweep mask change only applies next sweep.
    data_base = 12'h200; mask = 4'b1010;
    push_s(2'(CH_IPANEL)); push_s(2'(CH_IRR)); push_d(); push_s(2'(CH_VPANEL)); push_d();
    enable = 1'b1;
    wait_for(1, 200, "t2_first_sample");
    mask = 4'b0001;
    wait_for(0, 200, "t2_done_a");
    wait_for(0, 200, "t2_done_b");
    enable = 1'b0;
    idle_cycles(3);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);
    rd_ch = 2'(CH_IPANEL); #1;
    chk("t2_rd_ipanel", 32'(rd_data), 32'h201);
    rd_ch = 2'(CH_TEMP); #1;
    chk("t2_rd_temp_kept", 32'(rd_data), 32'h102);
    rd_ch = 2'(CH_VPANEL); #1;
    chk("t2_rd_vpanel", 32'(rd_data), 32'h200);

    // Empty mask: done two cycles after each tick, never a request.
    t_done.delete(); req_seen = 1'b0; mask = 4'b0000; period = 16'd5;
    push_d(); push_d(); push_d();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_for(3, 50, "t3_busy");
      @(negedge clk);
      chk("t3_done_after_busy", 32'(sweep_done), 1);
      chk("t3_busy_dropped", 32'(busy), 0);
    end
    enable = 1'b0;
    idle_cycles(3);
    chk("t3_done_spacing", 32'(t_done[2] - t_done[1]), 6);
    chk("t3_no_req", 32'(req_seen), 0);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // Back-to-back ticks with slow acks: overrun, set beats clear.
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    chk("t4_clr_idle", 32'(overrun), 0);
    data_base = 12'h300; ack_delay = 40; mask = 4'b0001; period = 16'd0;
    push_s(2'(CH_VPANEL)); push_d();
    enable = 1'b1;
    wait_for(2, 100, "t4_req");
    chk("t4_busy", 32'(busy), 1);
    chk("t4_overrun_set", 32'(overrun), 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("t4_set_wins", 32'(overrun), 1);
    wait_for(0, 200, "t4_done");
    enable = 1'b0;
    idle_cycles(2);
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    chk("t4_clr_after", 32'(overrun), 0);
    chk("t4_queue_empty", 32'(exp_q.size()), 0);
`ifndef SOLAR_ADC_TIMEOUT_EN
    chk("t4_timeout_tied", 32'(timeout_err), 0);
`endif

    // Disable during CONVERT: sample stored, no done pulse, back to idle.
    t_done.delete(); data_base = 12'h400; ack_delay = 10; period = 16'd3;
    push_s(2'(CH_VPANEL));
    enable = 1'b1;
    wait_for(2, 100, "t5_req");
    enable = 1'b0;
    wait_for(1, 50, "t5_sample");
    chk("t5_busy_at_sample", 32'(busy), 0);
    idle_cycles(30);
    chk("t5_req_low", 32'(bus.adc_req_o), 0);
    chk("t5_no_done", 32'(t_done.size()), 0);
    chk("t5_queue_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a handshake.
    ack_delay = 20; mask = 4'b0100; period = 16'd0; rd_ch = 2'(CH_IPANEL);
    enable = 1'b1;
    wait_for(2, 100, "t6_req");
    chk("t6_ch_before", 32'(bus.adc_ch_o), 2);
    chk("t6_rd_before", 32'(rd_data), 32'h201);
    rst_n = 1'b0; #1;
    chk("t6_req_dropped", 32'(bus.adc_req_o), 0);
    chk("t6_ch_cleared", 32'(bus.adc_ch_o), 0);
    chk("t6_busy_cleared", 32'(busy), 0);
    chk("t6_overrun_cleared", 32'(overrun), 0);
    chk("t6_rd_cleared", 32'(rd_data), 0);
    chk("t6_sample_data_cleared", 32'(sample_data), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

`ifdef SOLAR_ADC_TIMEOUT_EN
    // Withheld ack on ch1: timeout, no ch1 sample, sweep continues.
    ch1_req_cyc = 0; data_base = 12'h600; ack_delay = 3; mask = 4'b0111; period = 16'd20;
    hold_en = 1'b1; hold_ch = 2'(CH_IPANEL);
    push_s(2'(CH_VPANEL)); push_s(2'(CH_TEMP)); push_d();
    enable = 1'b1;
    wait_for(0, 1000, "t7_done");
    enable = 1'b0;
    hold_en = 1'b0;
    idle_cycles(3);
    chk("t7_timeout_err", 32'(timeout_err), 1);
    chk("t7_req_cycles", 32'(ch1_req_cyc), 255);
    chk("t7_queue_empty", 32'(exp_q.size()), 0);
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    chk("t7_timeout_clr", 32'(timeout_err), 0);
`endif

    idle_cycles(5);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
